// File: rtl/hls_kernel_run_sequencer.sv
// Run sequencer for a Bambu HLS kernel: kernel reset, memory preload, start, timed wait for done,
// and one result record per run, repeated for a configured batch of runs.
//
// state      | meaning
// S_IDLE     | waiting for a batch request, kernel held in reset
// S_KRST     | kernel reset pulse, RST_CYCLES long
// S_LOAD     | accepting preload words, one slave RAM write per word
// S_LOAD_END | write cycle of the last preload word
// S_START    | one-cycle kernel start pulse, cycle counter = 1
// S_WAIT     | counting cycles until done, timeout or abort
// S_REPORT   | result record offered until accepted
module hls_kernel_run_sequencer #(
    parameter int              ADDR_W     = 20,
    parameter int              DATA_W     = 64,
    parameter int              CYC_W      = 32,
    parameter int              RUNS_W     = 16,
    parameter longint unsigned TIMEOUT    = 200000000,
    parameter int              RST_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [RUNS_W-1:0] cfg_runs,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              cfg_skip_load,
    input  logic              abort,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              k_rst_n,
    output logic              k_start,
    input  logic              k_done,
    output logic              S_we_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [DATA_W-1:0] S_Wdata_ram,
    output logic [7:0]        S_data_ram_size,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CYC_W-1:0]  res_cycles,
    output logic [1:0]        res_status,
    output logic [RUNS_W-1:0] res_run_idx,
    output logic              busy
);
    localparam int                RC_W      = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0]   RC_LOAD   = RC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0]  TIMEOUT_C = CYC_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_KRST, S_LOAD, S_LOAD_END, S_START, S_WAIT, S_REPORT
    } state_t;

    state_t state, state_nxt;

    logic [RUNS_W-1:0] runs_q, run_idx;
    logic [ADDR_W-1:0] base_q, wr_addr;
    logic              skip_q, cancel_q;
    logic [RC_W-1:0]   rst_cnt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic              ld_acc, res_hs, more_runs, finish;
    logic [1:0]        fin_status;

    assign ld_acc    = ld_valid & ld_ready;
    assign res_hs    = res_valid & res_ready;
    assign more_runs = ({1'b0, run_idx} + (RUNS_W+1)'(1)) < {1'b0, runs_q};

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cfg_ready  = 1'b0;
        ld_ready   = 1'b0;
        k_rst_n    = 1'b1;
        k_start    = 1'b0;
        busy       = 1'b1;
        finish     = 1'b0;
        fin_status = 2'b00;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                k_rst_n   = 1'b0;
                busy      = 1'b0;
                if (cfg_valid) state_nxt = S_KRST;
            end
            S_KRST: begin
                k_rst_n = 1'b0;
                if (abort) begin
                    finish     = 1'b1;
                    fin_status = 2'b10;
                end else if (rst_cnt == '0) begin
                    state_nxt = skip_q ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (abort) begin
                    finish     = 1'b1;
                    fin_status = 2'b10;
                end else if (ld_acc && ld_last) begin
                    state_nxt = S_LOAD_END;
                end
            end
            S_LOAD_END: begin
                if (abort) begin
                    finish     = 1'b1;
                    fin_status = 2'b10;
                end else begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                k_start = 1'b1;
                if (abort) begin
                    finish     = 1'b1;
                    fin_status = 2'b10;
                end else if (k_done) begin
                    finish = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // done is checked before the timeout compare so a coinciding done wins
                if (abort) begin
                    finish     = 1'b1;
                    fin_status = 2'b10;
                end else if (k_done) begin
                    finish = 1'b1;
                end else if (cyc_cnt == TIMEOUT_C) begin
                    finish     = 1'b1;
                    fin_status = 2'b01;
                end
            end
            S_REPORT: begin
                if (res_hs) state_nxt = (more_runs && !cancel_q) ? S_KRST : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (finish) state_nxt = S_REPORT;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            runs_q          <= '0;
            run_idx         <= '0;
            base_q          <= '0;
            wr_addr         <= '0;
            skip_q          <= 1'b0;
            cancel_q        <= 1'b0;
            rst_cnt         <= '0;
            cyc_cnt         <= '0;
            S_we_ram        <= 1'b0;
            S_addr_ram      <= '0;
            S_Wdata_ram     <= '0;
            S_data_ram_size <= '0;
            res_valid       <= 1'b0;
            res_cycles      <= '0;
            res_status      <= '0;
            res_run_idx     <= '0;
        end else begin
            S_we_ram        <= ld_acc;
            S_data_ram_size <= ld_acc ? 8'(DATA_W) : 8'd0;
            if (ld_acc) begin
                S_addr_ram  <= wr_addr;
                S_Wdata_ram <= ld_data;
                wr_addr     <= wr_addr + STRIDE;
            end

            if (state == S_IDLE && cfg_valid) begin
                runs_q   <= (cfg_runs == '0) ? RUNS_W'(1) : cfg_runs;
                base_q   <= cfg_base;
                skip_q   <= cfg_skip_load;
                run_idx  <= '0;
                cancel_q <= 1'b0;
            end

            // each run restarts its preload address and cycle count at kernel reset
            if (state_nxt == S_KRST && state != S_KRST) begin
                rst_cnt <= RC_LOAD;
                cyc_cnt <= '0;
                wr_addr <= (state == S_IDLE) ? cfg_base : base_q;
            end else if (state == S_KRST && rst_cnt != '0) begin
                rst_cnt <= rst_cnt - RC_W'(1);
            end

            if (state_nxt == S_START && state != S_START) begin
                cyc_cnt <= CYC_W'(1);
            end else if ((state == S_START || state == S_WAIT) && !finish) begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end

            if (finish) begin
                res_valid   <= 1'b1;
                res_cycles  <= (fin_status == 2'b01) ? TIMEOUT_C : cyc_cnt;
                res_status  <= fin_status;
                res_run_idx <= run_idx;
                if (fin_status == 2'b10) cancel_q <= 1'b1;
            end else if (res_hs) begin
                res_valid <= 1'b0;
                run_idx   <= run_idx + RUNS_W'(1);
            end
        end
    end
endmodule

// File: doc/hls_kernel_run_sequencer.md
Name: hls_kernel_run_sequencer

Overview:
Synthesizable run sequencer for a Bambu-generated HLS kernel. It replaces the fixed simulation-only start/done harness with a parametrised, reusable controller. For each run it resets the kernel, preloads kernel memory through the slave RAM port, pulses start and measures cycles to done with timeout and abort. It repeats for a configured number of runs and emits one result record per run over a valid/ready interface.

Parameters:
ADDR_W, 20, slave RAM address width
DATA_W, 64, preload word width (multiple of 8, max 128)
CYC_W, 32, cycle counter and result width
RUNS_W, 16, run-count width
TIMEOUT, 200000000, cycles before a run is declared timed out (1 < TIMEOUT < 2^CYC_W)
RST_CYCLES, 2, cycles k_rst_n is held low before each run (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
cfg_valid  in  1  run-batch request
cfg_ready  out  1  high only in IDLE
cfg_runs  in  RUNS_W  number of runs; 0 treated as 1
cfg_base  in  ADDR_W  preload base byte address
cfg_skip_load  in  1  1: no preload phase
abort  in  1  single-cycle abort request
ld_valid  in  1  preload word valid
ld_ready  out  1  high only in LOAD
ld_data  in  DATA_W  preload word
ld_last  in  1  last word of this run's preload
k_rst_n  out  1  kernel reset, active-low
k_start  out  1  kernel start_port
k_done  in  1  kernel done_port (1-cycle pulse)
S_we_ram  out  1  slave write enable
S_addr_ram  out  ADDR_W  slave byte address
S_Wdata_ram  out  DATA_W  slave write data
S_data_ram_size  out  8  access size in bits, equal to DATA_W while writing, else 0
res_valid  out  1  result record valid
res_ready  in  1  result record accepted
res_cycles  out  CYC_W  measured cycles
res_status  out  2  00 done, 01 timeout, 10 aborted
res_run_idx  out  RUNS_W  0-based run index
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, sampled at clock edge) puts the FSM in IDLE and clears all registers. Reset values: k_rst_n=0, k_start=0, S_we_ram=0, S_addr_ram=0, S_Wdata_ram=0, S_data_ram_size=0, res_*=0, busy=0, ld_ready=0. cfg_ready=1 from the first cycle after reset deasserts.
- IDLE: k_rst_n=0. cfg_valid&cfg_ready latches runs (0->1), base and skip, clears run_idx, then goes to KRST.
- KRST: k_rst_n=0 for exactly RST_CYCLES cycles. Next state is LOAD, or START if skip=1.
- LOAD: k_rst_n=1, ld_ready=1. Each accepted word drives a 1-cycle S_we_ram on the next cycle with S_addr_ram=cfg_base+i*(DATA_W/8) for word i, counting from 0 per run. The address wraps modulo 2^ADDR_W. An accepted word with ld_last=1 goes to START after its write cycle. Throughput is one word per cycle.
- START: k_start=1 for exactly one cycle; cycle counter := 1. If k_done is sampled this same cycle, the run finishes with res_cycles=1.
- WAIT: counter increments every cycle. k_done gives status 00 and res_cycles=counter value in the done cycle. If counter reaches TIMEOUT with no done, status is 01 and res_cycles=TIMEOUT. When done and timeout coincide, done wins.
- k_done outside START/WAIT is ignored.
- REPORT: res_valid held with stable fields until res_ready; k_rst_n=1. On handshake, run_idx++. If run_idx+1 < runs, go to KRST, else IDLE.
- abort in KRST/LOAD/START/WAIT goes to REPORT with status 10, res_cycles=current counter (0 if not started), and the remaining runs cancelled (REPORT then goes to IDLE).
- abort in REPORT/IDLE is ignored.
- Abort during LOAD drops any pending ld handshake (ld_ready falls next cycle); a write already issued completes.
- A reset mid-operation abandons the run immediately: no result record, k_rst_n=0 in the same cycle reset is sampled.

Test Plan:
- Reset asserted 3 cycles mid-WAIT -> next cycle k_rst_n=0, busy=0, res_valid=0; cfg_ready=1 after release.
- cfg_runs=1, base=0x100, 3 words 0xA,0xB,0xC (DATA_W=64), kernel model done 10 cycles after start -> writes at 0x100/0x108/0x110, size=64, single k_start pulse, res_cycles=11, status 00, run_idx 0.
- cfg_runs=3, skip_load=1, done latencies 1,5,0(same-cycle) -> three records, cycles 2,6,1, idx 0,1,2, each preceded by exactly RST_CYCLES of k_rst_n=0.
- TIMEOUT=50, kernel never done -> status 01, res_cycles=50; done pulse arriving in the counter==50 cycle -> status 00, cycles 50.
- cfg_runs=4, abort during run 1 WAIT at counter 7 -> record idx 1, status 10, cycles 7, then IDLE with no further runs.
- res_ready held low 20 cycles -> res fields stable, no k_start until accepted; base 0xFFFF8 with 2 words (ADDR_W=20) -> second write at 0x00000.
